// File: rtl/pipe_hazard_scoreboard.sv
// Hazard, forwarding and stall controller for an in-order pipeline.
// Tracks destination registers of in-flight instructions and holds EX during multi-cycle ops.
module pipe_hazard_scoreboard #(
  parameter int NUM_STAGES = 3,
  parameter int MC_LATENCY = 32,
  parameter int FWD_W      = $clog2(NUM_STAGES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_use_i,
  input  logic             id_rs2_use_i,
  input  logic [4:0]       id_rd_addr_i,
  input  logic             id_rd_we_i,
  input  logic             id_is_load_i,
  input  logic             id_is_branch_i,
  input  logic             id_is_mc_i,
  input  logic             flush_i,
  output logic [FWD_W-1:0] alu_forward_a_o,
  output logic [FWD_W-1:0] alu_forward_b_o,
  output logic             branch_forward_a_o,
  output logic             branch_forward_b_o,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             control_pass_o,
  output logic             ex_hold_o,
  output logic             mc_busy_o
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } entry_t;

  entry_t     stg_q [NUM_STAGES];
  logic [4:0] rs1_q, rs2_q;
  logic       rs1_use_q, rs2_use_q;
  logic [6:0] mc_cnt;

  logic hold, load_use, br_stall, stall;

  // rd = x0 never produces a match, so x0 readers are never stalled or forwarded
  function automatic logic hit(input logic [4:0] a, input logic u, input entry_t e);
    return u && e.valid && e.we && (e.rd != 5'd0) && (e.rd == a);
  endfunction

  assign hold      = (mc_cnt != 7'd0);
  assign ex_hold_o = hold;
  assign mc_busy_o = hold;

  always_comb begin
    load_use = (hit(id_rs1_addr_i, id_rs1_use_i, stg_q[0]) ||
                hit(id_rs2_addr_i, id_rs2_use_i, stg_q[0])) && stg_q[0].ld;
    br_stall = id_is_branch_i &&
               (hit(id_rs1_addr_i, id_rs1_use_i, stg_q[0]) ||
                hit(id_rs2_addr_i, id_rs2_use_i, stg_q[0]) ||
                ((hit(id_rs1_addr_i, id_rs1_use_i, stg_q[1]) ||
                  hit(id_rs2_addr_i, id_rs2_use_i, stg_q[1])) && stg_q[1].ld));
    stall          = load_use || br_stall;
    control_pass_o = !stall && !flush_i;
    pc_en_o        = !hold && (flush_i || !stall);
    if_id_en_o     = pc_en_o;
    branch_forward_a_o = hit(id_rs1_addr_i, id_rs1_use_i, stg_q[1]) && !stg_q[1].ld;
    branch_forward_b_o = hit(id_rs2_addr_i, id_rs2_use_i, stg_q[1]) && !stg_q[1].ld;
  end

  // scan oldest to youngest so the youngest producer overwrites
  always_comb begin
    alu_forward_a_o = '0;
    alu_forward_b_o = '0;
    for (int k = NUM_STAGES - 1; k >= 1; k--) begin
      if (hit(rs1_q, rs1_use_q, stg_q[k])) alu_forward_a_o = FWD_W'(k);
      if (hit(rs2_q, rs2_use_q, stg_q[k])) alu_forward_b_o = FWD_W'(k);
    end
    if (!stg_q[0].valid) begin
      alu_forward_a_o = '0;
      alu_forward_b_o = '0;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int k = 0; k < NUM_STAGES; k++) stg_q[k] <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rs1_use_q <= 1'b0;
      rs2_use_q <= 1'b0;
      mc_cnt    <= '0;
    end else if (hold) begin
      stg_q[1] <= '0;
      for (int k = 2; k < NUM_STAGES; k++) stg_q[k] <= stg_q[k-1];
      mc_cnt <= mc_cnt - 7'd1;
    end else begin
      for (int k = 1; k < NUM_STAGES; k++) stg_q[k] <= stg_q[k-1];
      rs1_q     <= id_rs1_addr_i;
      rs2_q     <= id_rs2_addr_i;
      rs1_use_q <= control_pass_o && id_rs1_use_i;
      rs2_use_q <= control_pass_o && id_rs2_use_i;
      if (control_pass_o) begin
        stg_q[0] <= '{valid: 1'b1, rd: id_rd_addr_i, we: id_rd_we_i, ld: id_is_load_i};
        mc_cnt   <= id_is_mc_i ? 7'(MC_LATENCY - 1) : 7'd0;
      end else begin
        stg_q[0] <= '0;
      end
    end
  end

endmodule

// File: doc/pipe_hazard_scoreboard.md
# pipe_hazard_scoreboard

Parametrised hazard, forwarding and stall controller for the RV32IM_Zbb in-order pipeline. It tracks destination registers of in-flight instructions across `NUM_STAGES` post-ID stages and generates ALU-operand and branch-operand forwarding selects. It produces load-use and branch-use stalls, and holds EX while a multi-cycle M-extension operation (div/rem) completes. It sits in the control path between the control decoder (ID) and the datapath pipeline enables.

## Interface
- `NUM_STAGES`, 3: tracked stages after ID. Stage 0 = EX, 1 = MEM, …, NUM_STAGES-1 = WB; range 3..6.
- `MC_LATENCY`, 32: cycles a multi-cycle op occupies EX; range 1..64. A value of 1 means no hold.
- `FWD_W`, derived as $clog2(NUM_STAGES): forwarding select width.

Ports:
- `clk` in 1: the single clock; rising edge.
- `rst_n` in 1: reset, asynchronous, active-high despite the name.
- `id_rs1_addr_i`, `id_rs2_addr_i` in 5 each: source registers of the instruction in ID.
- `id_rs1_use_i`, `id_rs2_use_i` in 1 each: ID instruction reads rs1 / rs2.
- `id_rd_addr_i` in 5: destination register of the ID instruction.
- `id_rd_we_i` in 1: ID instruction writes rd.
- `id_is_load_i`, `id_is_branch_i`, `id_is_mc_i` in 1 each: ID instruction is a load / branch / multi-cycle op.
- `flush_i` in 1: discard the ID instruction; a bubble enters EX.
- `alu_forward_a_o`, `alu_forward_b_o` out FWD_W each: EX operand source. 0 = regfile/ID-EX latch; k = result of stage k (1..NUM_STAGES-1).
- `branch_forward_a_o`, `branch_forward_b_o` out 1 each: ID comparator operand taken from stage 1.
- `pc_en_o`, `if_id_en_o` out 1 each: PC and IF/ID register enables.
- `control_pass_o` out 1: 1 = ID control enters ID/EX; 0 = bubble.
- `ex_hold_o` out 1: ID/EX register must hold (multi-cycle in progress).
- `mc_busy_o` out 1: multi-cycle unit busy.

## Operation
- Per-stage entry: {valid, rd[4:0], rd_we, is_load}. Stage 0 additionally stores rs1, rs2, rs1_use, rs2_use and is_mc. An entry with rd = 0 never matches any source register.
- Advance, when not holding:
  - stage k+1 ← stage k;
  - stage 0 ← ID fields if `control_pass_o`, otherwise an invalid entry.
- Multi-cycle hold:
  - When a valid `is_mc` entry is written into stage 0, `mc_cnt` ← MC_LATENCY-1.
  - While `mc_cnt` ≠ 0: stage 0 holds, stage 1 receives an invalid entry, stages ≥ 2 advance, and `mc_cnt` decrements.
  - `ex_hold_o` = `mc_busy_o` = (`mc_cnt` ≠ 0).
- Load-use stall: ID uses rs1 or rs2 equal to stage 0 rd, and stage 0 is a valid load with we.
- Branch stall: `id_is_branch_i` and a used source matches either of:
  - stage 0 rd (valid, we, any type);
  - stage 1 rd (valid, we, load).
- `stall` = load-use OR branch stall. When `stall` or `ex_hold_o` is high: `pc_en_o` = `if_id_en_o` = 0.
- `control_pass_o` = !`stall` & !`flush_i`. It is don't-care while `ex_hold_o` is high, because stage 0 holds.
- Priority:
  - `ex_hold_o` overrides everything; `flush_i` is ignored while holding, and upstream keeps it asserted.
  - Otherwise `flush_i` overrides `stall`: bubble into EX, `pc_en_o` = `if_id_en_o` = 1.
- ALU forward (per operand, from stage 0 rs):
  - Select the lowest k in 1..NUM_STAGES-1 with a valid, we, matching rd. The youngest producer wins; 0 if none.
  - Forced to 0 when the rs_use bit is 0 or stage 0 is invalid.
- Branch forward: 1 when the ID source is used, matches stage 1 rd, and stage 1 is valid, we, non-load. Computed regardless of `id_is_branch_i`.

## Timing
- Reset (asynchronous): all entries invalid and `mc_cnt` = 0. Combinational outputs then read: forwards 0, `pc_en_o` = `if_id_en_o` = 1, `ex_hold_o` = `mc_busy_o` = 0, `control_pass_o` = !`flush_i`.
- Forward and stall outputs are combinational from registered state plus ID inputs; there is no added latency.
- Load-use costs exactly 1 bubble. A branch depending on an EX ALU result costs 1; on an EX load, 2.
- A multi-cycle op stalls IF/ID for MC_LATENCY-1 cycles starting the cycle after it enters EX; EX is occupied for MC_LATENCY cycles total.
- Reset asserted mid-hold clears `mc_cnt` immediately; on the next cycle after release, enables read 1.

## Test plan
- Back-to-back ALU producer then consumer: `add x5` then `sub` using x5, NUM_STAGES=3 → consumer in EX sees `alu_forward_a_o` = 1. With one instruction between them → 2.
- `lw x7` then `add x8,x7,x1` → one cycle with `pc_en_o` = `if_id_en_o` = `control_pass_o` = 0, then `alu_forward_a_o` = 2.
- `beq` on x3, with an EX ALU writer of x3 → 1 stall, then `branch_forward_a_o` = 1. With an EX load of x3 → 2 stalls.
- `div x4` with MC_LATENCY=4 → `ex_hold_o` high for exactly 3 cycles, `pc_en_o` low the same 3 cycles, 3 bubbles reach MEM. A dependent `add x9,x4,x0` then gets `alu_forward_a_o` = 1.
- `flush_i` during a load-use stall → `control_pass_o` = 0 and `pc_en_o` = 1 that cycle. `flush_i` during a div hold → ignored, hold continues.
- rd = x0 producer followed by an x0 consumer → all forwards 0, no stall. Assert `rst_n` mid-div → `mc_busy_o` drops asynchronously.
